// File: rtl/lockin_arb_pkg.sv
// Shared constants for the lock-in result arbiter: arbitration modes, stall width
// and packet field offsets ({tag, ts, freq, Y, X}, MSB to LSB).
package lockin_arb_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;
  localparam int   STALL_W        = 16;

  localparam int OFF_X = 0;
  function automatic int pkt_off_y(input int dw);             return dw;         endfunction
  function automatic int pkt_off_f(input int dw);             return 2 * dw;     endfunction
  function automatic int pkt_off_ts(input int dw);            return 3 * dw;     endfunction
  function automatic int pkt_off_tag(input int dw, input int tsw); return 3 * dw + tsw; endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Single-grant picker: round robin starting after `last`, or lowest index when mode is fixed.
module rr_priority_picker
  import lockin_arb_pkg::*;
#(
  parameter  int N  = 32,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic          mode,
  output logic [N-1:0]  gnt_onehot,
  output logic [LW-1:0] gnt_idx,
  output logic          any
);

  logic [LW-1:0] j;

  always_comb begin
    gnt_idx    = '0;
    any        = 1'b0;
    gnt_onehot = '0;
    j          = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == ARB_MODE_FIXED) j = LW'(i);
      else                        j = LW'((int'(last) + 1 + i) % N);
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = j;
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/lockin_result_arbiter.sv
// Collects lock-in channel results one per cycle into tagged, timestamped FIFO words,
// with a pending mask so a channel is not re-granted while its valid is still falling.
module lockin_result_arbiter
  import lockin_arb_pkg::*;
#(
  parameter  int LOCKIN_NUMBER = 32,
  parameter  int DATA_W        = 32,
  parameter  int TAG_W         = 8,
  parameter  int TS_W          = 16,
  localparam int PKT_W         = TAG_W + TS_W + 3 * DATA_W
) (
  input  logic                            clk_adc,
  input  logic                            reset,
  input  logic [LOCKIN_NUMBER-1:0]        ch_valid,
  input  logic [LOCKIN_NUMBER*DATA_W-1:0] ch_X,
  input  logic [LOCKIN_NUMBER*DATA_W-1:0] ch_Y,
  input  logic [LOCKIN_NUMBER*DATA_W-1:0] ch_freq,
  output logic [LOCKIN_NUMBER-1:0]        ch_read,
  input  logic [LOCKIN_NUMBER-1:0]        ch_enable,
  input  logic                            arb_mode,
  input  logic                            clear_stats,
  input  logic                            fifo_full,
  output logic                            fifo_wrreq,
  output logic [PKT_W-1:0]                fifo_data,
  output logic [STALL_W-1:0]              stall_count
);

  localparam int N       = LOCKIN_NUMBER;
  localparam int LW      = (N > 1) ? $clog2(N) : 1;
  localparam int OFF_Y   = pkt_off_y(DATA_W);
  localparam int OFF_F   = pkt_off_f(DATA_W);
  localparam int OFF_TS  = pkt_off_ts(DATA_W);
  localparam int OFF_TAG = pkt_off_tag(DATA_W, TS_W);

  logic [TS_W-1:0]    ts_q;
  logic [N-1:0]       pend_q, pend_d;
  logic [LW-1:0]      last_q;
  logic               wr_q;
  logic [N-1:0]       rd_q;
  logic [PKT_W-1:0]   data_q, pkt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [N-1:0]  elig, gnt_oh;
  logic [LW-1:0] gnt_idx;
  logic          gnt_any, grant;

  assign elig = ch_valid & ch_enable & ~pend_q;

  rr_priority_picker #(.N(N)) u_pick (
    .req       (elig),
    .last      (last_q),
    .mode      (arb_mode),
    .gnt_onehot(gnt_oh),
    .gnt_idx   (gnt_idx),
    .any       (gnt_any)
  );

  assign grant = gnt_any & ~fifo_full;

  always_comb begin
    pkt_d = '0;
    pkt_d[OFF_X   +: DATA_W] = ch_X[int'(gnt_idx) * DATA_W +: DATA_W];
    pkt_d[OFF_Y   +: DATA_W] = ch_Y[int'(gnt_idx) * DATA_W +: DATA_W];
    pkt_d[OFF_F   +: DATA_W] = ch_freq[int'(gnt_idx) * DATA_W +: DATA_W];
    pkt_d[OFF_TS  +: TS_W]   = ts_q;
    pkt_d[OFF_TAG +: TAG_W]  = TAG_W'(gnt_idx);
  end

  // Pending drops once valid is seen low; a new grant can only target a non-pending bit.
  always_comb begin
    pend_d = pend_q & ch_valid;
    if (grant) pend_d = pend_d | gnt_oh;
  end

  always_comb begin
    stall_d = stall_q;
    if (clear_stats)                                 stall_d = '0;
    else if (fifo_full && (|elig) && stall_q != '1)  stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      ts_q    <= '0;
      pend_q  <= '0;
      last_q  <= LW'(N - 1);
      wr_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      pend_q  <= pend_d;
      wr_q    <= grant;
      rd_q    <= grant ? gnt_oh : '0;
      stall_q <= stall_d;
      if (grant) begin
        data_q <= pkt_d;
        last_q <= gnt_idx;
      end
    end
  end

  assign ch_read     = rd_q;
  assign fifo_wrreq  = wr_q;
  assign fifo_data   = data_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_lockin_result_arbiter.sv
// Directed bench for lockin_result_arbiter with four 8-bit channels.
module tb_lockin_result_arbiter;

  localparam int N = 4, DW = 8, TW = 8, SW = 16, PW = TW + SW + 3 * DW;

  logic          clk_adc = 1'b0;
  logic          reset;
  logic [N-1:0]  ch_valid, ch_enable, ch_read;
  logic [N*DW-1:0] ch_X, ch_Y, ch_freq;
  logic          arb_mode, clear_stats, fifo_full, fifo_wrreq;
  logic [PW-1:0] fifo_data;
  logic [15:0]   stall_count;

  int n_cmp = 0, n_err = 0;
  int cnt[N];

  lockin_result_arbiter #(.LOCKIN_NUMBER(N), .DATA_W(DW), .TAG_W(TW), .TS_W(SW)) dut (
    .clk_adc(clk_adc), .reset(reset), .ch_valid(ch_valid), .ch_X(ch_X), .ch_Y(ch_Y),
    .ch_freq(ch_freq), .ch_read(ch_read), .ch_enable(ch_enable), .arb_mode(arb_mode),
    .clear_stats(clear_stats), .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .stall_count(stall_count)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input int k, input int ts);
    logic [7:0] tg, f, y, x;
    logic [15:0] t;
    tg = 8'(k); t = 16'(ts); f = 8'(8'h30 + k); y = 8'(8'h20 + k); x = 8'(8'h10 + k);
    return {tg, t, f, y, x};
  endfunction

  task automatic quiesce();
    ch_valid  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [N-1:0] exp_rd;
    for (int k = 0; k < N; k++) begin
      ch_X[k*DW +: DW]    = 8'(8'h10 + k);
      ch_Y[k*DW +: DW]    = 8'(8'h20 + k);
      ch_freq[k*DW +: DW] = 8'(8'h30 + k);
      cnt[k] = 0;
    end
    reset = 1'b1; ch_valid = '0; ch_enable = '1; arb_mode = 1'b0;
    clear_stats = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    chk("rst_read",  64'(ch_read), 64'h0);
    chk("rst_wrreq", 64'(fifo_wrreq), 64'h0);
    chk("rst_data",  64'(fifo_data), 64'h0);
    chk("rst_stall", 64'(stall_count), 64'h0);

    // 1: four valid channels drain in order with consecutive timestamps
    reset = 1'b0; ch_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t1_wrreq", 64'(fifo_wrreq), 64'h1);
      chk("t1_read",  64'(ch_read), 64'(4'b0001 << k));
      chk("t1_data",  64'(fifo_data), 64'(pkt(k, k)));
      ch_valid = ch_valid & ~ch_read;
    end
    tick();
    chk("t1_idle_wrreq", 64'(fifo_wrreq), 64'h0);
    chk("t1_idle_hold",  64'(fifo_data), 64'(pkt(3, 3)));

    // 2: ch 2 held high is granted once; others toggle and keep getting served
    ch_valid = 4'b1111;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("t2_onehot", 64'($onehot0(ch_read)), 64'h1);
      for (int k = 0; k < N; k++) if (ch_read[k]) cnt[k]++;
      for (int k = 0; k < N; k++) if (k != 2) ch_valid[k] = ~ch_read[k];
    end
    chk("t2_ch2_once", 64'(cnt[2]), 64'd1);
    chk("t2_ch0_served", 64'(cnt[0] >= 25), 64'h1);
    chk("t2_ch1_served", 64'(cnt[1] >= 25), 64'h1);
    chk("t2_ch3_served", 64'(cnt[3] >= 25), 64'h1);
    quiesce();

    // 3: fixed priority, ch 3 only fills the gaps while ch 1 is pending
    arb_mode = 1'b1; ch_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_rd = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      chk("t3_read", 64'(ch_read), 64'(exp_rd));
      chk("t3_tag",  64'(fifo_data[PW-1 -: TW]), (c % 2 == 0) ? 64'd1 : 64'd3);
      ch_valid[1] = ~ch_read[1];
      ch_valid[3] = ~ch_read[3];
    end
    arb_mode = 1'b0;
    quiesce();

    // 4: full stalls ch 0 for 10 cycles, then it is written; clear_stats zeroes the counter
    chk("t4_stall0", 64'(stall_count), 64'h0);
    fifo_full = 1'b1; ch_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_full_wrreq", 64'(fifo_wrreq), 64'h0);
    end
    chk("t4_stall10", 64'(stall_count), 64'd10);
    fifo_full = 1'b0;
    tick();
    chk("t4_wrreq", 64'(fifo_wrreq), 64'h1);
    chk("t4_read",  64'(ch_read), 64'h1);
    chk("t4_tag",   64'(fifo_data[PW-1 -: TW]), 64'd0);
    chk("t4_stall_keep", 64'(stall_count), 64'd10);
    ch_valid = '0; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t4_clear", 64'(stall_count), 64'h0);
    quiesce();

    // 5: disabled channel is neither granted nor counted as a stall
    ch_enable = 4'b1101; ch_valid = 4'b0010; fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("t5_no_stall", 64'(stall_count), 64'h0);
    fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_grant", 64'(fifo_wrreq), 64'h0);
    end
    ch_enable = '1;
    tick();
    chk("t5_enabled_read", 64'(ch_read), 64'b0010);
    quiesce();

    // 6: reset right after a grant of ch 3; it is re-granted with timestamp 0
    ch_valid = 4'b1000;
    tick();
    chk("t6_grant3", 64'(ch_read), 64'b1000);
    reset = 1'b1;
    tick();
    chk("t6_rst_read",  64'(ch_read), 64'h0);
    chk("t6_rst_wrreq", 64'(fifo_wrreq), 64'h0);
    chk("t6_rst_data",  64'(fifo_data), 64'h0);
    reset = 1'b0;
    tick();
    chk("t6_regrant", 64'(ch_read), 64'b1000);
    chk("t6_data",    64'(fifo_data), 64'(pkt(3, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
